// File: rtl/ip_config_loader.sv
// Loads IP/gateway/subnet/MAC from an 18-byte AXI-Stream frame and commits it atomically one cycle after tlast.
// Always ready outside reset (no backpressure); short or long frames pulse cfg_error and leave outputs untouched.
module ip_config_loader #(
  parameter logic [31:0] C_DEFAULT_IP      = 32'h0,
  parameter logic [31:0] C_DEFAULT_GATEWAY = 32'h0,
  parameter logic [31:0] C_DEFAULT_SUBNET  = 32'h0,
  parameter logic [47:0] C_DEFAULT_MAC     = 48'h0
) (
  input  logic        aclk,
  input  logic        aresetn,
  input  logic [7:0]  s_axis_tdata,
  input  logic        s_axis_tvalid,
  output logic        s_axis_tready,
  input  logic        s_axis_tlast,
  output logic [31:0] ip,
  output logic [31:0] gateway,
  output logic [31:0] subnet,
  output logic [47:0] mac,
  output logic [47:0] mac_big,
  output logic        cfg_valid,
  output logic        cfg_error,
  output logic        cfg_loaded
);

  localparam logic [0:0] RECV  = 1'b0;
  localparam logic [0:0] DRAIN = 1'b1;
  localparam logic [4:0] LAST_IDX = 5'd17;

  logic [0:0]   state;
  logic [4:0]   cnt;
  // Bytes 0..16 shift in here; byte 17 is taken straight from the bus on commit.
  logic [135:0] shadow;
  logic         beat;

  assign s_axis_tready = aresetn;
  assign beat          = s_axis_tvalid && s_axis_tready;

  assign mac_big = {mac[7:0], mac[15:8], mac[23:16], mac[31:24], mac[39:32], mac[47:40]};

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state      <= RECV;
      cnt        <= 5'd0;
      shadow     <= '0;
      ip         <= C_DEFAULT_IP;
      gateway    <= C_DEFAULT_GATEWAY;
      subnet     <= C_DEFAULT_SUBNET;
      mac        <= C_DEFAULT_MAC;
      cfg_valid  <= 1'b0;
      cfg_error  <= 1'b0;
      cfg_loaded <= 1'b0;
    end else begin
      cfg_valid <= 1'b0;
      cfg_error <= 1'b0;
      if (beat) begin
        case (state)
          RECV: begin
            shadow <= {shadow[127:0], s_axis_tdata};
            if (s_axis_tlast) begin
              cnt <= 5'd0;
              if (cnt == LAST_IDX) begin
                ip         <= shadow[135:104];
                gateway    <= shadow[103:72];
                subnet     <= shadow[71:40];
                mac        <= {shadow[39:0], s_axis_tdata};
                cfg_valid  <= 1'b1;
                cfg_loaded <= 1'b1;
              end else begin
                cfg_error <= 1'b1;
              end
            end else if (cnt == LAST_IDX) begin
              state <= DRAIN;
              cnt   <= 5'd0;
            end else begin
              cnt <= cnt + 5'd1;
            end
          end
          default: begin
            if (s_axis_tlast) begin
              cfg_error <= 1'b1;
              state     <= RECV;
              cnt       <= 5'd0;
            end
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ip_config_loader.sv
// Scoreboard bench for ip_config_loader: stimulus queues expected pulses, a monitor checks them and the live outputs.
module tb_ip_config_loader;

  logic        aclk = 1'b0;
  logic        aresetn = 1'b0;
  logic [7:0]  s_axis_tdata = 8'h00;
  logic        s_axis_tvalid = 1'b0;
  logic        s_axis_tready;
  logic        s_axis_tlast = 1'b0;
  logic [31:0] ip, gateway, subnet;
  logic [47:0] mac, mac_big;
  logic        cfg_valid, cfg_error, cfg_loaded;

  ip_config_loader dut (
    .aclk(aclk), .aresetn(aresetn),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tready(s_axis_tready), .s_axis_tlast(s_axis_tlast),
    .ip(ip), .gateway(gateway), .subnet(subnet), .mac(mac), .mac_big(mac_big),
    .cfg_valid(cfg_valid), .cfg_error(cfg_error), .cfg_loaded(cfg_loaded)
  );

  always #5 aclk = ~aclk;

  typedef struct {
    bit          commit;
    logic [31:0] ip;
    logic [31:0] gw;
    logic [31:0] sn;
    logic [47:0] mac;
    logic [47:0] mbig;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  bit   mon_en = 1'b0;
  int   n_commits = 0;
  int   last_commit_cyc = 0;
  int   prev_commit_cyc = 0;

  logic [31:0] cur_ip, cur_gw, cur_sn;
  logic [47:0] cur_mac, cur_mbig;
  logic        cur_loaded;

  always @(posedge aclk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic exp_t mk_commit(logic [31:0] i, logic [31:0] g, logic [31:0] s,
                                     logic [47:0] m, logic [47:0] mb);
    exp_t e;
    e.commit = 1'b1; e.ip = i; e.gw = g; e.sn = s; e.mac = m; e.mbig = mb; e.cyc = 0;
    return e;
  endfunction

  function automatic exp_t mk_error();
    exp_t e;
    e.commit = 1'b0; e.ip = '0; e.gw = '0; e.sn = '0; e.mac = '0; e.mbig = '0; e.cyc = 0;
    return e;
  endfunction

  // Monitor: pops the scoreboard on every pulse, flags missing pulses, and checks live outputs every cycle.
  always @(negedge aclk) begin
    if (mon_en) begin
      if (cfg_valid || cfg_error) begin
        if (sb.size() == 0) begin
          check("unexpected_pulse", {cfg_valid, cfg_error}, 2'b00);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("pulse_cycle", cyc, e.cyc);
          check("pulse_kind", {cfg_valid, cfg_error}, e.commit ? 2'b10 : 2'b01);
          if (e.commit) begin
            cur_ip = e.ip; cur_gw = e.gw; cur_sn = e.sn;
            cur_mac = e.mac; cur_mbig = e.mbig; cur_loaded = 1'b1;
          end
          if (cfg_valid) begin
            n_commits++;
            prev_commit_cyc = last_commit_cyc;
            last_commit_cyc = cyc;
          end
        end
      end else if (sb.size() != 0 && sb[0].cyc < cyc) begin
        exp_t e;
        e = sb.pop_front();
        check(e.commit ? "missing_cfg_valid" : "missing_cfg_error", 1'b0, 1'b1);
        if (e.commit) begin
          cur_ip = e.ip; cur_gw = e.gw; cur_sn = e.sn;
          cur_mac = e.mac; cur_mbig = e.mbig; cur_loaded = 1'b1;
        end
      end
      check("ip", ip, cur_ip);
      check("gateway", gateway, cur_gw);
      check("subnet", subnet, cur_sn);
      check("mac", mac, cur_mac);
      check("mac_big", mac_big, cur_mbig);
      check("cfg_loaded", cfg_loaded, cur_loaded);
    end
  end

  task automatic do_reset(input int n);
    aresetn = 1'b0;
    s_axis_tvalid = 1'b0;
    s_axis_tlast = 1'b0;
    @(posedge aclk);
    #1;
    sb.delete();
    cur_ip = 32'h0; cur_gw = 32'h0; cur_sn = 32'h0;
    cur_mac = 48'h0; cur_mbig = 48'h0; cur_loaded = 1'b0;
    mon_en = 1'b1;
    repeat (n - 1) @(posedge aclk);
    @(negedge aclk);
    check("rst_ip", ip, 32'h0);
    check("rst_gateway", gateway, 32'h0);
    check("rst_subnet", subnet, 32'h0);
    check("rst_mac", mac, 48'h0);
    check("rst_mac_big", mac_big, 48'h0);
    check("rst_flags", {cfg_valid, cfg_error, cfg_loaded}, 3'b000);
    check("rst_tready", s_axis_tready, 1'b0);
    @(posedge aclk);
    #1;
    aresetn = 1'b1;
    @(posedge aclk);
    @(negedge aclk);
    check("tready_after_release", s_axis_tready, 1'b1);
    @(posedge aclk);
    #1;
  endtask

  // Called aligned to 1 time unit after a rising edge; returns with the same alignment.
  task automatic send_frame(input logic [7:0] bytes[$], input bit gaps, input bit end_last, input exp_t e);
    for (int i = 0; i < bytes.size(); i++) begin
      if (gaps) begin
        int g;
        g = $urandom_range(0, 2);
        repeat (g) begin
          @(posedge aclk);
          #1;
        end
      end
      s_axis_tdata  = bytes[i];
      s_axis_tvalid = 1'b1;
      s_axis_tlast  = end_last && (i == bytes.size() - 1);
      if (s_axis_tlast) begin
        e.cyc = cyc + 1;
        sb.push_back(e);
      end
      @(posedge aclk);
      #1;
      s_axis_tvalid = 1'b0;
      s_axis_tlast  = 1'b0;
    end
  endtask

  logic [7:0] f1[$];
  logic [7:0] f2[$];
  logic [7:0] fshort[$];
  logic [7:0] flong[$];
  logic [7:0] fpart[$];
  exp_t       e1, e2;

  initial begin
    f1 = '{8'h0A, 8'h01, 8'h02, 8'h03, 8'h0A, 8'h01, 8'h02, 8'hFE, 8'hFF,
           8'hFF, 8'hFF, 8'h00, 8'h00, 8'h0A, 8'h35, 8'h01, 8'h02, 8'h03};
    f2 = '{8'hC0, 8'hA8, 8'h00, 8'h07, 8'hC0, 8'hA8, 8'h00, 8'h01, 8'hFF,
           8'hFF, 8'h00, 8'h00, 8'h02, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    fshort = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88, 8'h99, 8'hAA};
    flong = '{8'h0A, 8'h01, 8'h02, 8'h03, 8'h0A, 8'h01, 8'h02, 8'hFE, 8'hFF, 8'hFF,
              8'hFF, 8'h00, 8'h00, 8'h0A, 8'h35, 8'h01, 8'h02, 8'h03, 8'hDE, 8'hAD};
    fpart = '{8'h0A, 8'h01, 8'h02, 8'h03, 8'h0A, 8'h01, 8'h02};
    e1 = mk_commit(32'h0A010203, 32'h0A0102FE, 32'hFFFFFF00, 48'h000A35010203, 48'h030201350A00);
    e2 = mk_commit(32'hC0A80007, 32'hC0A80001, 32'hFFFF0000, 48'h021122334455, 48'h554433221102);

    do_reset(3);

    send_frame(f1, 1'b1, 1'b1, e1);
    repeat (3) @(posedge aclk);
    #1;

    send_frame(fshort, 1'b0, 1'b1, mk_error());
    send_frame(f2, 1'b1, 1'b1, e2);
    repeat (3) @(posedge aclk);
    #1;

    send_frame(flong, 1'b0, 1'b1, mk_error());
    repeat (3) @(posedge aclk);
    #1;

    send_frame(fpart, 1'b0, 1'b0, mk_error());
    do_reset(2);
    send_frame(f1, 1'b0, 1'b1, e1);
    repeat (3) @(posedge aclk);
    #1;

    send_frame(f1, 1'b0, 1'b1, e1);
    send_frame(f2, 1'b0, 1'b1, e2);
    repeat (5) @(posedge aclk);
    @(negedge aclk);
    check("b2b_commit_spacing", last_commit_cyc - prev_commit_cyc, 18);
    check("final_ip", ip, 32'hC0A80007);
    check("final_mac_big", mac_big, 48'h554433221102);
    check("total_commits", n_commits, 5);
    check("scoreboard_empty", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
